// File: rtl/alu_pkg.sv
// Shared widths, scheduler FSM states and ALU operation codes for the ALU scheduler.
package alu_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_SLTU = 3'd7
    } alu_op_t;
endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; zero latency, no flow control.
// Results wrap to DATA_W bits; shifts use the low 3 bits of b.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
    output logic [DATA_W-1:0] o_y
);
    always_comb begin
        o_y = '0;
        case (alu_op_t'(i_op))
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_SHL:  o_y = i_a << i_b[2:0];
            OP_SHR:  o_y = i_a >> i_b[2:0];
            OP_SLTU: o_y = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
// Zero latency; produces an all-zero grant when nothing requests.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx
);
    logic w_found;
    int   w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (int'(i_ptr) + i) % NUM_REQ;
            if (!w_found && i_req[w_cand]) begin
                w_found        = 1'b1;
                o_gnt[w_cand]  = 1'b1;
                o_idx          = ID_W'(w_cand);
            end
        end
    end
endmodule

// File: rtl/alu_sched.sv
// Shares one ALU among NUM_REQ requesters: grant in IDLE, result valid 2 cycles later.
// A pending response holds RESP (and blocks new grants) until rsp_ready_i.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic [ID_W-1:0]           rsp_id_o,
    input  logic                      rsp_ready_i,
    output logic                      busy_o
);
    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [DATA_W-1:0]  w_alu_y;
    logic               w_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    alu u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_y  (w_alu_y)
    );

    // Gating with reset keeps the handshake from completing in a reset cycle.
    assign w_grant     = (r_state == ST_IDLE) && !reset && (|w_gnt);
    assign req_ready_o = w_grant ? w_gnt : '0;
    assign w_ptr_nxt   = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_idx + ID_W'(1));

    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_data_o  = r_data;
    assign rsp_id_o    = r_id;
    assign busy_o      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_a     <= req_a_i[w_idx*DATA_W +: DATA_W];
                        r_b     <= req_b_i[w_idx*DATA_W +: DATA_W];
                        r_op    <= req_op_i[w_idx*OP_W +: OP_W];
                        r_id    <= w_idx;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_data  <= w_alu_y;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed table, corner sequences, randomized scoreboard sweep.
module tb_alu_sched;
    localparam int N = 4;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } op_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid_i;
    logic [N*8-1:0] req_a_i;
    logic [N*8-1:0] req_b_i;
    logic [N*3-1:0] req_op_i;
    logic [N-1:0]  req_ready_o;
    logic          rsp_valid_o;
    logic [7:0]    rsp_data_o;
    logic [1:0]    rsp_id_o;
    logic          rsp_ready_i;
    logic          busy_o;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    vec_t tbl [10];
    op_t  req_q [N][$];
    rsp_t exp_q [$];
    int   gcyc [$];
    int   gid [$];
    int   rid [$];

    always #5 clk = ~clk;

    alu_sched #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_op_i    (req_op_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_ready_i (rsp_ready_i),
        .busy_o      (busy_o)
    );

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [7:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[2:0];
            3'd6: r = a >> b[2:0];
            default: r = (a < b) ? 8'd1 : 8'd0;
        endcase
        return r;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
        cyc_n++;
    endtask

    task automatic drive_all(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_valid_i = v;
        for (int i = 0; i < N; i++) begin
            req_a_i[i*8 +: 8]  = a;
            req_b_i[i*8 +: 8]  = b;
            req_op_i[i*3 +: 3] = op;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req_valid_i = '0;
        cyc();
        reset = 1'b0;
    endtask

    function automatic bit all_done(input bit outst);
        bit d;
        d = !outst;
        for (int i = 0; i < N; i++) if (req_q[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    initial begin
        bit         outstanding;
        int         m_ptr;
        int         grant_cyc;
        int         n_rsp;
        int         g;
        int         idx;
        logic [3:0] vld;
        logic [3:0] exp_g;
        logic       exp_v;
        op_t        h;
        rsp_t       r;

        tbl[0] = '{4'b0100, 8'h12, 8'h34, 3'd0, 4'b0100, 2'd2, 8'h46};
        tbl[1] = '{4'b1010, 8'hF0, 8'h20, 3'd0, 4'b0010, 2'd1, 8'h10};
        tbl[2] = '{4'b1000, 8'h05, 8'h07, 3'd1, 4'b1000, 2'd3, 8'hFE};
        tbl[3] = '{4'b1111, 8'hCC, 8'hAA, 3'd2, 4'b0001, 2'd0, 8'h88};
        tbl[4] = '{4'b0110, 8'hC0, 8'h0C, 3'd3, 4'b0010, 2'd1, 8'hCC};
        tbl[5] = '{4'b1100, 8'hFF, 8'h0F, 3'd4, 4'b0100, 2'd2, 8'hF0};
        tbl[6] = '{4'b0001, 8'h81, 8'h03, 3'd5, 4'b0001, 2'd0, 8'h08};
        tbl[7] = '{4'b0010, 8'h81, 8'h0B, 3'd6, 4'b0010, 2'd1, 8'h10};
        tbl[8] = '{4'b1000, 8'h10, 8'h20, 3'd7, 4'b1000, 2'd3, 8'h01};
        tbl[9] = '{4'b0000, 8'h55, 8'h66, 3'd0, 4'b0000, 2'd0, 8'h00};

        reset       = 1'b1;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_op_i    = '0;
        rsp_ready_i = 1'b1;

        // Reset state, with every requester asserting valid during reset.
        req_valid_i = '1;
        cyc();
        cyc();
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data_o), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);

        // Directed table, each vector applied from a fresh reset.
        for (int k = 0; k < 10; k++) begin
            do_reset();
            rsp_ready_i = 1'b1;
            drive_all(tbl[k].valid, tbl[k].a, tbl[k].b, tbl[k].op);
            #1;
            chk("tbl_ready", 32'(req_ready_o), 32'(tbl[k].exp_rdy));
            cyc();
            req_valid_i = '0;
            #1;
            chk("tbl_busy", 32'(busy_o), 32'(tbl[k].exp_rdy != 0));
            chk("tbl_exec_novalid", 32'(rsp_valid_o), 32'h0);
            cyc();
            #1;
            chk("tbl_rsp_valid", 32'(rsp_valid_o), 32'(tbl[k].exp_rdy != 0));
            if (tbl[k].exp_rdy != 0) begin
                chk("tbl_rsp_id", 32'(rsp_id_o), 32'(tbl[k].exp_id));
                chk("tbl_rsp_data", 32'(rsp_data_o), 32'(tbl[k].exp_data));
            end
            cyc();
            #1;
            chk("tbl_after_valid", 32'(rsp_valid_o), 32'h0);
            chk("tbl_after_busy", 32'(busy_o), 32'h0);
        end

        // All four requesting continuously: grants 0,1,2,3,0 every 3 cycles.
        do_reset();
        rsp_ready_i = 1'b1;
        drive_all(4'b1111, 8'h01, 8'h02, 3'd0);
        for (int c = 0; c < 15; c++) begin
            if (c > 0) cyc();
            #1;
            if (req_ready_o != 0) begin
                gcyc.push_back(c);
                gid.push_back(onehot_idx(req_ready_o));
            end
            if (rsp_valid_o) rid.push_back(int'(rsp_id_o));
        end
        chk("rr_grant_count", 32'(gid.size()), 32'd5);
        chk("rr_rsp_count", 32'(rid.size()), 32'd5);
        for (int k = 0; k < gid.size(); k++) begin
            chk("rr_grant_order", 32'(gid[k]), 32'(k % 4));
            if (k > 0) chk("rr_grant_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
        end
        for (int k = 0; k < rid.size(); k++) chk("rr_rsp_order", 32'(rid[k]), 32'(k % 4));
        req_valid_i = '0;

        // Back-pressure: response held for 10 cycles, other requesters ignored.
        do_reset();
        rsp_ready_i = 1'b0;
        drive_all(4'b0001, 8'h3C, 8'h0F, 3'd4);
        #1;
        chk("bp_grant", 32'(req_ready_o), 32'h1);
        cyc();
        req_valid_i = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            cyc();
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'h1);
            chk("bp_rsp_data", 32'(rsp_data_o), 32'h33);
            chk("bp_rsp_id", 32'(rsp_id_o), 32'h0);
            chk("bp_ready_zero", 32'(req_ready_o), 32'h0);
        end
        rsp_ready_i = 1'b1;
        cyc();
        #1;
        chk("bp_release_valid", 32'(rsp_valid_o), 32'h0);
        chk("bp_release_busy", 32'(busy_o), 32'h0);
        chk("bp_release_grant", 32'(req_ready_o), 32'h2);
        req_valid_i = '0;

        // Wrap-around: move pointer to 3, then 0011 must pick 0 and leave pointer at 1.
        do_reset();
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_all(4'(1 << k), 8'h11, 8'h22, 3'd0);
            #1;
            chk("wrap_setup_grant", 32'(req_ready_o), 32'(1 << k));
            cyc();
            req_valid_i = '0;
            cyc();
            cyc();
        end
        drive_all(4'b0011, 8'h11, 8'h22, 3'd0);
        #1;
        chk("wrap_grant0", 32'(req_ready_o), 32'h1);
        cyc();
        req_valid_i = '0;
        cyc();
        cyc();
        req_valid_i = 4'b0011;
        #1;
        chk("wrap_ptr1", 32'(req_ready_o), 32'h2);
        cyc();
        req_valid_i = '0;
        cyc();
        #1;
        chk("wrap_rsp_data", 32'(rsp_data_o), 32'h33);
        cyc();

        // Reset during EXEC of requester 1 discards the operation.
        req_valid_i = 4'b0010;
        #1;
        chk("rexec_grant", 32'(req_ready_o), 32'h2);
        cyc();
        reset       = 1'b1;
        req_valid_i = '0;
        cyc();
        reset = 1'b0;
        #1;
        chk("rexec_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rexec_rsp_data", 32'(rsp_data_o), 32'h0);
        chk("rexec_rsp_id", 32'(rsp_id_o), 32'h0);
        chk("rexec_busy", 32'(busy_o), 32'h0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            chk("rexec_no_rsp", 32'(rsp_valid_o), 32'h0);
        end
        req_valid_i = 4'b1111;
        #1;
        chk("rexec_ptr0", 32'(req_ready_o), 32'h1);
        cyc();
        req_valid_i = '0;
        cyc();
        cyc();

        // Randomized sweep against a scoreboard model.
        do_reset();
        m_ptr       = 0;
        outstanding = 1'b0;
        grant_cyc   = 0;
        n_rsp       = 0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 16; k++) begin
                h.a  = 8'($urandom);
                h.b  = 8'($urandom);
                h.op = 3'(k % 8);
                req_q[i].push_back(h);
            end
        for (int c = 0; c < 4000 && !all_done(outstanding); c++) begin
            cyc();
            vld = '0;
            for (int i = 0; i < N; i++) begin
                if (req_q[i].size() != 0 && $urandom_range(0, 3) != 0) begin
                    vld[i]              = 1'b1;
                    req_a_i[i*8 +: 8]   = req_q[i][0].a;
                    req_b_i[i*8 +: 8]   = req_q[i][0].b;
                    req_op_i[i*3 +: 3]  = req_q[i][0].op;
                end else begin
                    req_a_i[i*8 +: 8]   = 8'($urandom);
                    req_b_i[i*8 +: 8]   = 8'($urandom);
                    req_op_i[i*3 +: 3]  = 3'($urandom);
                end
            end
            req_valid_i = vld;
            rsp_ready_i = ($urandom_range(0, 2) != 0);
            #1;
            g = -1;
            if (!outstanding)
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && vld[idx]) g = idx;
                end
            exp_g = '0;
            if (g >= 0) exp_g[g] = 1'b1;
            chk("rnd_ready", 32'(req_ready_o), 32'(exp_g));
            exp_v = outstanding && (cyc_n - grant_cyc >= 2);
            chk("rnd_rsp_valid", 32'(rsp_valid_o), 32'(exp_v));
            if (exp_v && exp_q.size() != 0) begin
                chk("rnd_rsp_id", 32'(rsp_id_o), 32'(exp_q[0].id));
                chk("rnd_rsp_data", 32'(rsp_data_o), 32'(exp_q[0].data));
                if (rsp_ready_i) begin
                    void'(exp_q.pop_front());
                    outstanding = 1'b0;
                    n_rsp++;
                end
            end
            if (g >= 0) begin
                h       = req_q[g].pop_front();
                r.id    = 2'(g);
                r.data  = ref_alu(h.a, h.b, h.op);
                exp_q.push_back(r);
                outstanding = 1'b1;
                grant_cyc   = cyc_n;
                m_ptr       = (g + 1) % N;
            end
        end
        chk("rnd_rsp_total", 32'(n_rsp), 32'd64);
        chk("rnd_leftover", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one ALU (2..8).
REQ-002 Parameter ID_W, $clog2(NUM_REQ), width of requester index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid_i  input  NUM_REQ  per-requester operation request.
REQ-006 req_a_i  input  NUM_REQ x 8  per-requester first operand.
REQ-007 req_b_i  input  NUM_REQ x 8  per-requester second operand.
REQ-008 req_op_i  input  NUM_REQ x 3  per-requester encoded ALU operation.
REQ-009 req_ready_o  output  NUM_REQ  one-hot grant; request accepted when valid and ready are high in the same cycle.
REQ-010 rsp_valid_o  output  1  result available.
REQ-011 rsp_data_o  output  8  ALU result for the accepted request.
REQ-012 rsp_id_o  output  ID_W  index of requester that owns rsp_data_o.
REQ-013 rsp_ready_i  input  1  consumer accepts response when high with rsp_valid_o.
REQ-014 busy_o  output  1  high whenever FSM is not IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: if any req_valid_i bit is high, the block SHALL assert req_ready_o for exactly one winner that cycle, capture its a, b, op and index, and go to EXEC; otherwise stay IDLE with req_ready_o all zero.
REQ-017 req_ready_o SHALL be combinational from req_valid_i and the registered priority pointer, and SHALL be all zero outside IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at the priority pointer, wrapping from NUM_REQ-1 to 0; after a grant the pointer becomes (winner+1) mod NUM_REQ.
REQ-019 EXEC: captured operands SHALL drive the shared ALU; its output SHALL be registered into the result register; go to RESP unconditionally.
REQ-020 RESP: rsp_valid_o SHALL be high; rsp_data_o and rsp_id_o SHALL stay stable until rsp_ready_i is high; on that edge go to IDLE.
REQ-021 Latency: grant in cycle N SHALL give rsp_valid_o high from cycle N+2; max throughput one operation per 3 cycles with rsp_ready_i held high.
REQ-022 No new grant SHALL occur while a response is pending (back-pressure via rsp_ready_i low holds RESP indefinitely).
REQ-023 req_valid_i changes while not in IDLE SHALL have no effect; a requester dropping valid before grant SHALL lose its slot without side effects.
REQ-024 Operand capture width SHALL be exact (8/8/3 bits); result SHALL be the ALU's 8-bit output unmodified, no saturation or carry-out.

Reset
REQ-025 Reset SHALL force IDLE, priority pointer 0, rsp_valid_o 0, rsp_data_o 8'h00, rsp_id_o 0, busy_o 0, req_ready_o all zero.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-027 No grant SHALL be issued in any cycle where reset is high.

Structure
REQ-028 Shared package alu_pkg SHALL hold DATA_W=8, OP_W=3 and the FSM state enum.
REQ-029 The existing combinational alu module SHALL be instantiated once as the shared datapath.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant, winner index).

Verification
REQ-031 Single request: req_valid_i=4'b0100, a=8'h12, b=8'h34, op=3'd0 -> req_ready_o=4'b0100 same cycle; rsp_valid_o at +2 cycles, rsp_id_o=2, rsp_data_o equals alu(8'h12,8'h34,0).
REQ-032 All four requesting continuously after reset, rsp_ready_i=1 -> grant order 0,1,2,3,0; one response every 3 cycles; ids match order.
REQ-033 Back-pressure: rsp_ready_i=0 for 10 cycles in RESP -> rsp_valid_o, rsp_data_o, rsp_id_o stable, req_ready_o all zero; release -> IDLE next cycle.
REQ-034 Wrap-around: pointer=3, req_valid_i=4'b0011 -> grant requester 0, pointer becomes 1.
REQ-035 Reset in EXEC after granting requester 1 -> no response; next cycle outputs at reset values, pointer 0.
REQ-036 Random sweep: all 8 ops x random operands from all requesters -> every response matches alu model and correct id; no lost or duplicated requests.
